posit_encoder: RTL and testbench
================================

Name: posit_encoder

Overview:
- Pipelined posit encoder. Converts an unpacked posit value (class, sign, combined scale, MSB-aligned fraction) into a WIDTH-bit posit word using round-to-nearest-even.
- Inverse of the operand decoder. Sits at the output of the posit MAC/adder datapath and writes results back to posit storage.
- Elastic valid/ready handshake on both sides, 2-stage pipeline.

Parameters:
- WIDTH, 8, posit word width.
- EXP, 2, exponent field width (es).
- FRAC_W, 8, input fraction width; hidden bit excluded; MSB = 2^-1.
- SCALE_W, 8, signed scale width; must hold ±2*(2^EXP)*(WIDTH-2).

Ports:
- clk_i  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- vld_i  in  1  input valid.
- rdy_o  out  1  input ready.
- cls_i  in  2  operand class: 00 zero, 10 NaR, 01 normal, 11 treated as NaR.
- sign_i  in  1  sign (1 = negative).
- scale_i  in  SCALE_W  signed; value = regime*2^EXP + exp.
- frac_i  in  FRAC_W  fraction bits, MSB-aligned.
- sticky_i  in  1  OR of any fraction bits the upstream stage already discarded.
- vld_o  out  1  output valid.
- rdy_i  in  1  downstream ready.
- pout  out  WIDTH  encoded posit.

Behaviour:
- Reset (async, rstn=0): vld_o=0, pout=0, all internal stage-valid flags 0. rdy_o=1 one cycle after reset release. Mid-operation reset drops in-flight data, with no output pulse.
- Handshake:
  - Transfer in on vld_i&rdy_o; transfer out on vld_o&rdy_i.
  - rdy_o = ~s1_vld | (~s2_vld | rdy_i); combinational, no bubble.
  - Stage s2 holds pout/vld_o stable while vld_o&~rdy_i.
  - Throughput 1/cycle. Latency 2 cycles from accepted input to vld_o.
- Stage 1, registered on input transfer:
  - k = scale_i >>> EXP (arithmetic); e = scale_i[EXP-1:0].
  - Saturation flags: sat_hi = (scale_i >= (2^EXP)*(WIDTH-2)); sat_lo = (scale_i < -(2^EXP)*(WIDTH-2)).
  - Regime string: k>=0 gives k+1 ones then a zero; k<0 gives -k zeros then a one.
  - Build {regime, e, frac_i} and right-align it into the WIDTH-1 magnitude field.
  - Keep the first truncated bit as guard (G). Keep the OR of all further truncated bits plus sticky_i as S.
  - Exponent bits pushed past the field take part in G/S.
- Stage 2, registered on s1→s2 transfer:
  - L = LSB of the kept magnitude.
  - Round up iff G & (L | S).
  - Clamp: magnitude never becomes 0 and never exceeds 0x7F..F (maxpos).
  - sat_hi forces maxpos; sat_lo forces minpos (00..01).
  - Sign: pout = sign ? two's complement of {0,mag} : {0,mag}.
- Class overrides:
  - cls=00 gives pout=0 regardless of the other inputs.
  - cls=10/11 gives pout={1,0..0} (NaR).
  - A normal class never yields 0 or NaR.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both honoured.
  - Back-to-back inputs under rdy_i=0 fill s1 and s2, then rdy_o=0. No data loss or duplication.

Decomposition:
- Shared package posit_pkg:
  - Class codes CLS_ZERO=2'b00, CLS_VALID=2'b01, CLS_NAR=2'b10, shared with the decoder.
  - Localparams USEED and MAXK=WIDTH-2.
  - Functions maxpos(WIDTH) and minpos(WIDTH).
- One sub-module, posit_round_rne: combinational guard/sticky RNE with clamp. Instantiated in stage 2 and reusable by the decoder-side normaliser.

Test Plan (WIDTH=8, EXP=2, FRAC_W=8):
- Exact values:
  - cls=01, sign=0, scale=0, frac=0x00 → pout=0x40 after 2 cycles.
  - Same with sign=1 → 0xC0.
  - scale=4, frac=0 → 0x60.
  - scale=1, frac=0x80 → 0x4C.
- RNE ties:
  - scale=0, frac=0x10, sticky=0 → 0x40 (tie, round to even).
  - frac=0x30 → 0x42.
  - frac=0x10 with sticky_i=1 → 0x41.
- Saturation:
  - scale=30 → 0x7F; scale=24 → 0x7F.
  - scale=-40 → 0x01; scale=-40 with sign=1 → 0xFF.
  - scale=-24 → 0x01.
- Classes: cls=00 with random fields → 0x00; cls=10 → 0x80.
- Backpressure:
  - Stream 4 inputs with rdy_i held 0.
  - rdy_o must drop after the 2nd accept and vld_o must hold its first value.
  - Release rdy_i: 4 outputs in order, one per cycle, no gaps.
- Reset mid-stream:
  - Assert rstn=0 with s1 and s2 full → vld_o=0 and pout=0 immediately.
  - After release, the first new input emerges after exactly 2 cycles.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit definitions: class codes, default geometry and special-value helpers.
package posit_pkg;

  localparam int unsigned P_WIDTH = 8;
  localparam int unsigned P_EXP   = 2;
  localparam int unsigned MAXK    = P_WIDTH - 2;
  localparam int unsigned USEED   = 1 << (1 << P_EXP);

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'b00,
    CLS_VALID = 2'b01,
    CLS_NAR   = 2'b10
  } cls_e;

  // Largest positive posit pattern 0111..1 for a w-bit word.
  function automatic logic [31:0] maxpos(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  // Smallest positive posit pattern 000..01.
  function automatic logic [31:0] minpos(input int unsigned w);
    return 32'(w != 0);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Guard/sticky round-to-nearest-even on a posit magnitude, clamped to [minpos, maxpos].
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int unsigned MAG_W = P_WIDTH - 1
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  output logic [MAG_W-1:0] mag_c_o
);

  localparam logic [MAG_W-1:0] MAG_MAX = MAG_W'(maxpos(MAG_W + 1));
  localparam logic [MAG_W-1:0] MAG_MIN = MAG_W'(minpos(MAG_W + 1));

  logic round_up_c;

  always_comb begin
    round_up_c = guard_i & (mag_i[0] | sticky_i);
    mag_c_o    = mag_i;
    if (round_up_c && (mag_i != MAG_MAX)) mag_c_o = mag_i + MAG_W'(1);
    if (mag_c_o == '0) mag_c_o = MAG_MIN;
  end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage elastic posit encoder: stage 1 builds the regime/exp/fraction string,
// stage 2 rounds RNE, applies saturation, class overrides and sign.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int unsigned WIDTH   = P_WIDTH,
  parameter int unsigned EXP     = P_EXP,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned SCALE_W = 8
) (
  input  logic               clk_i,
  input  logic               rstn,
  input  logic               vld_i,
  output logic               rdy_o,
  input  logic [1:0]         cls_i,
  input  logic               sign_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [FRAC_W-1:0]  frac_i,
  input  logic               sticky_i,
  output logic               vld_o,
  input  logic               rdy_i,
  output logic [WIDTH-1:0]   pout
);

  localparam int unsigned MAG_W = WIDTH - 1;
  localparam int unsigned MAX_K = WIDTH - 2;
  localparam int unsigned PAD   = MAX_K;
  localparam int unsigned TW    = 2 + EXP + FRAC_W + PAD;
  localparam int unsigned LO_W  = TW - WIDTH;

  localparam logic signed [SCALE_W-1:0] SAT_HI = SCALE_W'((1 << EXP) * MAX_K);
  localparam logic signed [SCALE_W-1:0] SAT_LO = -SAT_HI;
  localparam logic [MAG_W-1:0] MAG_MAX = MAG_W'(maxpos(WIDTH));
  localparam logic [MAG_W-1:0] MAG_MIN = MAG_W'(minpos(WIDTH));

  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [1:0] s1_cls_q, s1_cls_d;
  logic s1_sign_q, s1_sign_d, s1_sat_hi_q, s1_sat_hi_d, s1_sat_lo_q, s1_sat_lo_d;
  logic s1_g_q, s1_g_d, s1_s_q, s1_s_d;
  logic [MAG_W-1:0] s1_mag_q, s1_mag_d;
  logic [WIDTH-1:0] pout_q, pout_d;

  logic s1_en_c, s2_en_c;
  logic signed [SCALE_W-1:0] k_c;
  logic [SCALE_W-1:0] sh_c;
  logic signed [TW-1:0] seed_c, str_c;
  logic [MAG_W-1:0] rnd_mag_c, mag_fin_c;
  logic [WIDTH-1:0] enc_c;

  assign s2_en_c = ~s2_vld_q | rdy_i;
  assign s1_en_c = ~s1_vld_q | s2_en_c;
  assign rdy_o   = s1_en_c;
  assign vld_o   = s2_vld_q;
  assign pout    = pout_q;

  // Regime seed "10" (k>=0) or "01" (k<0), arithmetic shift replicates the leading run.
  always_comb begin
    k_c  = $signed(scale_i) >>> EXP;
    sh_c = k_c[SCALE_W-1] ? ~k_c : k_c;
    if (sh_c > SCALE_W'(MAX_K)) sh_c = SCALE_W'(MAX_K);
    seed_c = {~k_c[SCALE_W-1], k_c[SCALE_W-1], scale_i[EXP-1:0], frac_i, {PAD{1'b0}}};
    str_c  = seed_c >>> sh_c;
  end

  posit_round_rne #(.MAG_W(MAG_W)) u_round (
    .mag_i    (s1_mag_q),
    .guard_i  (s1_g_q),
    .sticky_i (s1_s_q),
    .mag_c_o  (rnd_mag_c)
  );

  always_comb begin
    mag_fin_c = s1_sat_hi_q ? MAG_MAX : (s1_sat_lo_q ? MAG_MIN : rnd_mag_c);
    if (s1_cls_q == CLS_ZERO)  enc_c = '0;
    else if (s1_cls_q[1])      enc_c = {1'b1, {MAG_W{1'b0}}};
    else if (s1_sign_q)        enc_c = -{1'b0, mag_fin_c};
    else                       enc_c = {1'b0, mag_fin_c};
  end

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_cls_d    = s1_cls_q;
    s1_sign_d   = s1_sign_q;
    s1_sat_hi_d = s1_sat_hi_q;
    s1_sat_lo_d = s1_sat_lo_q;
    s1_mag_d    = s1_mag_q;
    s1_g_d      = s1_g_q;
    s1_s_d      = s1_s_q;
    s2_vld_d    = s2_vld_q;
    pout_d      = pout_q;
    if (s1_en_c) begin
      s1_vld_d = vld_i;
      if (vld_i) begin
        s1_cls_d    = cls_i;
        s1_sign_d   = sign_i;
        s1_sat_hi_d = $signed(scale_i) >= SAT_HI;
        s1_sat_lo_d = $signed(scale_i) < SAT_LO;
        s1_mag_d    = str_c[TW-1 -: MAG_W];
        s1_g_d      = str_c[LO_W];
        s1_s_d      = (|str_c[LO_W-1:0]) | sticky_i;
      end
    end
    if (s2_en_c) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) pout_d = enc_c;
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_cls_q    <= 2'b00;
      s1_sign_q   <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s1_mag_q    <= '0;
      s1_g_q      <= 1'b0;
      s1_s_q      <= 1'b0;
      s2_vld_q    <= 1'b0;
      pout_q      <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_cls_q    <= s1_cls_d;
      s1_sign_q   <= s1_sign_d;
      s1_sat_hi_q <= s1_sat_hi_d;
      s1_sat_lo_q <= s1_sat_lo_d;
      s1_mag_q    <= s1_mag_d;
      s1_g_q      <= s1_g_d;
      s1_s_q      <= s1_s_d;
      s2_vld_q    <= s2_vld_d;
      pout_q      <= pout_d;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (8-bit, es=2): exact values, RNE ties, saturation,
// classes, backpressure and mid-stream reset.
module tb_posit_encoder;
  import posit_pkg::*;

  logic       clk_i = 1'b0;
  logic       rstn;
  logic       vld_i, rdy_o, sign_i, sticky_i, vld_o, rdy_i;
  logic [1:0] cls_i;
  logic [7:0] scale_i, frac_i, pout;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  posit_encoder #(.WIDTH(8), .EXP(2), .FRAC_W(8), .SCALE_W(8)) dut (
    .clk_i    (clk_i),
    .rstn     (rstn),
    .vld_i    (vld_i),
    .rdy_o    (rdy_o),
    .cls_i    (cls_i),
    .sign_i   (sign_i),
    .scale_i  (scale_i),
    .frac_i   (frac_i),
    .sticky_i (sticky_i),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i),
    .pout     (pout)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cls, input logic sign, input logic [7:0] scale,
                       input logic [7:0] frac, input logic sticky);
    cls_i = cls; sign_i = sign; scale_i = scale; frac_i = frac; sticky_i = sticky;
    vld_i = 1'b1;
  endtask

  // One transaction with rdy_i=1: accepted at the next edge, visible after the one after.
  task automatic run_one(input string tag, input logic [1:0] cls, input logic sign,
                         input logic [7:0] scale, input logic [7:0] frac,
                         input logic sticky, input logic [7:0] exp);
    drive(cls, sign, scale, frac, sticky);
    chk({tag, "/rdy"}, 32'(rdy_o), 32'd1);
    @(posedge clk_i); #1;
    vld_i = 1'b0;
    chk({tag, "/lat1"}, 32'(vld_o), 32'd0);
    @(posedge clk_i); #1;
    chk({tag, "/vld"}, 32'(vld_o), 32'd1);
    chk({tag, "/pout"}, 32'(pout), 32'(exp));
  endtask

  initial begin
    $display("posit_encoder bench: WIDTH=%0d es=%0d useed=%0d", P_WIDTH, P_EXP, USEED);
    rstn = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
    cls_i = 2'b00; sign_i = 1'b0; scale_i = 8'h00; frac_i = 8'h00; sticky_i = 1'b0;
    #2;
    chk("rst/vld", 32'(vld_o), 32'd0);
    chk("rst/pout", 32'(pout), 32'd0);
    @(negedge clk_i); rstn = 1'b1;
    @(posedge clk_i); #1;
    chk("rst/rdy", 32'(rdy_o), 32'd1);

    // exact values
    run_one("one",      2'b01, 1'b0, 8'd0,     8'h00, 1'b0, 8'h40);
    run_one("minus1",   2'b01, 1'b1, 8'd0,     8'h00, 1'b0, 8'hC0);
    run_one("sc4",      2'b01, 1'b0, 8'd4,     8'h00, 1'b0, 8'h60);
    run_one("sc1f80",   2'b01, 1'b0, 8'd1,     8'h80, 1'b0, 8'h4C);
    run_one("scm1",     2'b01, 1'b0, 8'(-1),   8'h00, 1'b0, 8'h38);
    run_one("scm1neg",  2'b01, 1'b1, 8'(-1),   8'h00, 1'b0, 8'hC8);
    run_one("scm5",     2'b01, 1'b0, 8'(-5),   8'h00, 1'b0, 8'h1C);
    // RNE
    run_one("tie_even", 2'b01, 1'b0, 8'd0,     8'h10, 1'b0, 8'h40);
    run_one("tie_odd",  2'b01, 1'b0, 8'd0,     8'h30, 1'b0, 8'h42);
    run_one("tie_stk",  2'b01, 1'b0, 8'd0,     8'h10, 1'b1, 8'h41);
    run_one("exp_rnd",  2'b01, 1'b0, 8'(-21),  8'h00, 1'b0, 8'h02);
    run_one("rnd_max",  2'b01, 1'b0, 8'd23,    8'h00, 1'b0, 8'h7F);
    run_one("sc20",     2'b01, 1'b0, 8'd20,    8'h00, 1'b0, 8'h7E);
    // saturation
    run_one("sat30",    2'b01, 1'b0, 8'd30,    8'h00, 1'b0, 8'h7F);
    run_one("sat24",    2'b01, 1'b0, 8'd24,    8'hFF, 1'b1, 8'h7F);
    run_one("satm40",   2'b01, 1'b0, 8'(-40),  8'h00, 1'b0, 8'h01);
    run_one("satm40n",  2'b01, 1'b1, 8'(-40),  8'h00, 1'b0, 8'hFF);
    run_one("scm24",    2'b01, 1'b0, 8'(-24),  8'h00, 1'b0, 8'h01);
    // classes
    run_one("zero",     2'b00, 1'b1, 8'd5,     8'hA5, 1'b1, 8'h00);
    run_one("nar10",    2'b10, 1'b0, 8'd3,     8'h5A, 1'b0, 8'h80);
    run_one("nar11",    2'b11, 1'b1, 8'(-3),   8'h11, 1'b1, 8'h80);

    // backpressure: A=0x40 B=0x60 C=0x4C D=0x38
    @(posedge clk_i); #1;
    rdy_i = 1'b0;
    drive(2'b01, 1'b0, 8'd0, 8'h00, 1'b0);
    chk("bp/rdyA", 32'(rdy_o), 32'd1);
    @(posedge clk_i); #1;
    drive(2'b01, 1'b0, 8'd4, 8'h00, 1'b0);
    chk("bp/rdyB", 32'(rdy_o), 32'd1);
    @(posedge clk_i); #1;
    chk("bp/vldA", 32'(vld_o), 32'd1);
    chk("bp/poutA", 32'(pout), 32'h40);
    drive(2'b01, 1'b0, 8'd1, 8'h80, 1'b0);
    chk("bp/rdy_drop", 32'(rdy_o), 32'd0);
    @(posedge clk_i); #1;
    chk("bp/holdvld", 32'(vld_o), 32'd1);
    chk("bp/holdA", 32'(pout), 32'h40);
    chk("bp/rdy_low", 32'(rdy_o), 32'd0);
    rdy_i = 1'b1;
    #1;
    chk("bp/rdy_rel", 32'(rdy_o), 32'd1);
    @(posedge clk_i); #1;
    chk("bp/vldB", 32'(vld_o), 32'd1);
    chk("bp/poutB", 32'(pout), 32'h60);
    drive(2'b01, 1'b0, 8'(-1), 8'h00, 1'b0);
    @(posedge clk_i); #1;
    vld_i = 1'b0;
    chk("bp/vldC", 32'(vld_o), 32'd1);
    chk("bp/poutC", 32'(pout), 32'h4C);
    @(posedge clk_i); #1;
    chk("bp/vldD", 32'(vld_o), 32'd1);
    chk("bp/poutD", 32'(pout), 32'h38);
    @(posedge clk_i); #1;
    chk("bp/empty", 32'(vld_o), 32'd0);

    // reset with both stages full
    rdy_i = 1'b0;
    drive(2'b01, 1'b1, 8'd0, 8'h00, 1'b0);
    @(posedge clk_i); #1;
    drive(2'b01, 1'b0, 8'd4, 8'h00, 1'b0);
    @(posedge clk_i); #1;
    vld_i = 1'b0;
    chk("mr/full", 32'(rdy_o), 32'd0);
    chk("mr/pre", 32'(pout), 32'hC0);
    rstn = 1'b0;
    #1;
    chk("mr/vld", 32'(vld_o), 32'd0);
    chk("mr/pout", 32'(pout), 32'd0);
    @(negedge clk_i); rstn = 1'b1; rdy_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mr/novld", 32'(vld_o), 32'd0);
    run_one("mr/after", 2'b01, 1'b0, 8'd1, 8'h80, 1'b0, 8'h4C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
